// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load-type codes,
// stage state encoding and the execute-to-memory bus layout.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 110;
    localparam int MS_TO_WS_BUS_WD = 71;
    localparam int MS_FW_WD        = 39;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4,
        LD_LWL = 3'd5,
        LD_LWR = 3'd6
    } load_type_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } ms_state_e;

    // Field order matches es_to_ms_bus, MSB first
    typedef struct packed {
        logic        mem_req;
        logic [2:0]  load_type;
        logic [1:0]  addr_lo;
        logic [31:0] rt_value;
        logic        dest_valid;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_extract.sv
// Combinational load-data extraction: selects, extends and merges the returned
// little-endian word according to the load type and low address bits.
module load_extract
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] rt_value,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_type,
    output logic [31:0] extracted
);

    logic [4:0]  lwl_sh;
    logic [4:0]  lwr_sh;
    logic [31:0] shr;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // 8*(3-n) for a 2-bit n is the bitwise complement of n, scaled by 8
        lwl_sh   = {~addr_lo, 3'b000};
        lwr_sh   = {addr_lo, 3'b000};
        shr      = word >> lwr_sh;
        byte_sel = shr[7:0];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        extracted = word;
        case (load_type)
            LD_LB:   extracted = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  extracted = {24'h0, byte_sel};
            LD_LH:   extracted = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  extracted = {16'h0, half_sel};
            LD_LWL:  extracted = (word << lwl_sh)
                               | (rt_value & ~(32'hFFFF_FFFF << lwl_sh));
            LD_LWR:  extracted = shr
                               | (rt_value & ~(32'hFFFF_FFFF >> lwr_sh));
            default: extracted = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: holds one instruction, waits for the data-memory
// response when a request was issued, and forwards its pending result to decode.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ws_allowin,
    output logic                         ms_allowin,
    input  logic                         es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
    output logic                         ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
    input  logic                         data_sram_data_ok,
    input  logic [31:0]                  data_sram_rdata,
    output logic [MS_FW_WD-1:0]          ms_to_ds_fw
);

    es_to_ms_t   es_in;
    es_to_ms_t   ms_bus;
    logic        ms_valid;
    ms_state_e   state;
    ms_state_e   state_nxt;
    logic [31:0] data_buf;
    logic        ms_ready_go;
    logic        accept;
    logic        advance;
    logic [31:0] load_word;
    logic [31:0] extracted;
    logic [31:0] final_result;
    logic        ms_load_pending;

    always_comb begin
        es_in       = es_to_ms_bus;
        ms_ready_go = !ms_bus.mem_req || state == MS_DONE
                    || (state == MS_WAIT && data_sram_data_ok);
        ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
        accept      = es_to_ms_valid && ms_allowin;
        advance     = ms_valid && ms_ready_go && ws_allowin;
    end

    // A new accept overrides the advance; a response only settles when the stage holds
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = es_in.mem_req ? MS_WAIT : MS_IDLE;
        end else if (advance) begin
            state_nxt = MS_IDLE;
        end else if (state == MS_WAIT && data_sram_data_ok) begin
            state_nxt = MS_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            ms_bus   <= '0;
            state    <= MS_IDLE;
            data_buf <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (accept) begin
                ms_bus <= es_in;
            end
            state <= state_nxt;
            if (state == MS_WAIT && data_sram_data_ok) begin
                data_buf <= data_sram_rdata;
            end
        end
    end

    always_comb begin
        load_word = (state == MS_DONE) ? data_buf : data_sram_rdata;
    end

    load_extract u_load_extract (
        .word      (load_word),
        .rt_value  (ms_bus.rt_value),
        .addr_lo   (ms_bus.addr_lo),
        .load_type (ms_bus.load_type),
        .extracted (extracted)
    );

    always_comb begin
        final_result    = ms_bus.res_from_mem ? extracted : ms_bus.alu_result;
        ms_load_pending = ms_valid && ms_bus.res_from_mem && !ms_ready_go;
        ms_to_ws_valid  = ms_valid && ms_ready_go;
        ms_to_ws_bus    = {ms_bus.dest_valid, ms_bus.gr_we, ms_bus.dest,
                           final_result, ms_bus.pc};
        ms_to_ds_fw     = {ms_load_pending, ms_valid && ms_bus.dest_valid,
                           ms_bus.dest, final_result};
    end

endmodule
